ram_row_loader: RTL and testbench

- Writer-side front end for the multi-word row RAM used for weight and feature buffers.
- Accepts a valid/ready stream of DATA_WIDTH words and scatters them into RAM rows, one word lane at a time.
- Drives the RAM write port signals: wr_data, wr_addr, and one-hot wr_en.
- Fills rows 0..DEPTH-1 in order, lanes 0..NUM_WORDS-1 within each row, then reports completion.

---
 rtl/ram_row_loader_if.sv | 48 ++++
 rtl/ram_row_loader.sv | 155 +++++++++++++++
 tb/tb_ram_row_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_row_loader_if.sv
// ram_row_loader_if
// Bundles the stream input, RAM write port and status signals of the row
// loader so that they can be passed as one port.
//   slave  : view used by the loader (consumes the stream, drives the RAM port)
//   master : view used by the stream source / RAM side / testbench
// Signals:
//   start                  : one-cycle load request
//   in_data/in_valid       : stream word and qualifier
//   in_ready               : loader accepts a word this cycle
//   wr_data/wr_addr/wr_en  : RAM write port (wr_en is one-hot per lane)
//   busy/done              : load in progress / final-write pulse
//   checksum               : sum of accepted words (only with RAM_ROW_LOADER_CHECKSUM_EN)
interface ram_row_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int NUM_WORDS  = 288
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                  start;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [AW-1:0]         wr_addr;
   logic [NUM_WORDS-1:0]  wr_en;
   logic                  busy;
   logic                  done;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
   logic [31:0]           checksum;
`endif

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, wr_data, wr_addr, wr_en, busy, done
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
      , output checksum
`endif
   );

   modport master (
      output start, in_data, in_valid,
      input  in_ready, wr_data, wr_addr, wr_en, busy, done
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
      , input checksum
`endif
   );
endinterface

// File: rtl/ram_row_loader.sv
// ram_row_loader
// Writer-side front end for the multi-word row RAM. Accepts a valid/ready
// stream of DATA_WIDTH words and scatters them into RAM rows 0..DEPTH-1,
// lane 0..NUM_WORDS-1 within each row, then pulses done together with the
// final RAM write.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous, active-high reset
//   bus  : ram_row_loader_if.slave (stream in, RAM write port, status)
// Optional feature:
//   RAM_ROW_LOADER_CHECKSUM_EN : adds bus.checksum, the modulo-2^32 sum of
//   every accepted word of the current load, updated aligned with wr_en.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; in_ready=0, wr_en=0
// LOAD   | accepting beats; each accept writes one lane one cycle later
// DONE   | one cycle; final lane write and done pulse coincide here
module ram_row_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int NUM_WORDS  = 288
) (
   input logic             clk,
   input logic             rst,
   ram_row_loader_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [AW-1:0]        LAST_ROW  = AW'(DEPTH - 1);
   localparam logic [WW-1:0]        LAST_WORD = WW'(NUM_WORDS - 1);
   localparam logic [NUM_WORDS-1:0] LANE0     = NUM_WORDS'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         row_idx_q, row_idx_d;
   logic [WW-1:0]         word_idx_q, word_idx_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [AW-1:0]         wr_addr_q, wr_addr_d;
   logic [NUM_WORDS-1:0]  wr_en_q, wr_en_d;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
   logic [31:0]           checksum_q, checksum_d;
`endif

   logic in_ready;
   logic accept;
   logic last_word;
   logic last_row;

   // in_ready depends on state only so the source never sees a
   // combinational path from its own in_valid.
   assign in_ready  = (state_q == S_LOAD);
   assign accept    = in_ready && bus.in_valid;
   assign last_word = (word_idx_q == LAST_WORD);
   assign last_row  = (row_idx_q == LAST_ROW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_idx_q  <= '0;
         word_idx_q <= '0;
         wr_data_q  <= '0;
         wr_addr_q  <= '0;
         wr_en_q    <= '0;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         row_idx_q  <= row_idx_d;
         word_idx_q <= word_idx_d;
         wr_data_q  <= wr_data_d;
         wr_addr_q  <= wr_addr_d;
         wr_en_q    <= wr_en_d;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      row_idx_d  = row_idx_q;
      word_idx_d = word_idx_q;
      wr_data_d  = wr_data_q;
      wr_addr_d  = wr_addr_q;
      wr_en_d    = '0;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
      checksum_d = checksum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_LOAD;
               row_idx_d  = '0;
               word_idx_d = '0;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
               checksum_d = '0;
`endif
            end
         end

         S_LOAD: begin
            if (accept) begin
               wr_data_d = bus.in_data;
               wr_addr_d = row_idx_q;
               wr_en_d   = LANE0 << word_idx_q;
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
               checksum_d = checksum_q + 32'(bus.in_data);
`endif
               if (last_word) begin
                  word_idx_d = '0;
                  // Wrap rather than increment on the final row so the row
                  // counter never leaves 0..DEPTH-1 for non power-of-two DEPTH.
                  if (last_row) begin
                     row_idx_d = '0;
                     state_d   = S_DONE;
                  end else begin
                     row_idx_d = row_idx_q + AW'(1);
                  end
               end else begin
                  word_idx_d = word_idx_q + WW'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready = in_ready;
   assign bus.wr_data  = wr_data_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.busy     = (state_q == S_LOAD) || (state_q == S_DONE);
   // The last write lands in the DONE cycle, so done marks the final RAM write.
   assign bus.done     = (state_q == S_DONE);
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
   assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ram_row_loader.sv
// tb_ram_row_loader
// Directed bench for ram_row_loader with DATA_WIDTH=8, DEPTH=4, NUM_WORDS=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. A small model RAM captures the write port.
module tb_ram_row_loader;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int NW    = 3;
   localparam int BEATS = DEPTH * NW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_row_loader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) bus ();

   ram_row_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WORDS(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [DW-1:0] ram [DEPTH][NW];

   always @(posedge clk) begin
      for (int l = 0; l < NW; l++)
         if (bus.wr_en[l]) ram[bus.wr_addr][l] <= bus.wr_data;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_vec({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      check_vec({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
      check_vec({tag, "_busy"},     64'(bus.busy),     64'd0);
      check_vec({tag, "_done"},     64'(bus.done),     64'd0);
   endtask

   // One load. gap=1 inserts an idle cycle after every beat, mid_start
   // pulses start together with that beat index, abort_at pulses reset
   // instead of presenting that beat (-1 disables either).
   task automatic run_load(input logic [7:0] base, input bit const_data, input bit gap,
                           input int mid_start, input int abort_at);
      logic [7:0]  d;
      logic [31:0] sum;
      sum = 32'd0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_vec("load_in_ready", 64'(bus.in_ready), 64'd1);
      check_vec("load_busy",     64'(bus.busy),     64'd1);
      check_vec("load_wr_en0",   64'(bus.wr_en),    64'd0);
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
      check_vec("cks_cleared",   64'(bus.checksum), 64'd0);
`endif
      for (int k = 0; k < BEATS; k++) begin
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("abort");
            check_vec("abort_wr_data", 64'(bus.wr_data), 64'd0);
            check_vec("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
         d = const_data ? base : base + 8'(k);
         sum = sum + 32'(d);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         if (k == mid_start) bus.start = 1'b1;
         @(posedge clk);
         #1;
         check_vec("beat_wr_en",    64'(bus.wr_en),    64'(3'b001 << (k % NW)));
         check_vec("beat_wr_addr",  64'(bus.wr_addr),  64'(k / NW));
         check_vec("beat_wr_data",  64'(bus.wr_data),  64'(d));
         check_vec("beat_done",     64'(bus.done),     64'(k == BEATS - 1));
         check_vec("beat_in_ready", 64'(bus.in_ready), 64'(k != BEATS - 1));
         check_vec("beat_busy",     64'(bus.busy),     64'd1);
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
         check_vec("beat_checksum", 64'(bus.checksum), 64'(sum));
`endif
         @(negedge clk);
         bus.start    = 1'b0;
         bus.in_valid = 1'b0;
         if (gap && k != BEATS - 1) begin
            @(posedge clk);
            #1;
            check_vec("gap_wr_en", 64'(bus.wr_en), 64'd0);
            check_vec("gap_done",  64'(bus.done),  64'd0);
            @(negedge clk);
         end
      end
      // An excess word offered after completion must not be taken.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      @(posedge clk);
      #1;
      check_all_zero("post");
      check_vec("post_wr_data", 64'(bus.wr_data), 64'(d));
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #1;
      check_all_zero("rst");
      check_vec("rst_wr_data", 64'(bus.wr_data), 64'd0);
      check_vec("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         check_all_zero("idle");
         @(negedge clk);
      end
      bus.in_valid = 1'b0;

      run_load(8'h01, 1'b0, 1'b0, -1, -1);
      check_vec("ram_r2_l0", 64'(ram[2][0]), 64'h07);
      check_vec("ram_r2_l1", 64'(ram[2][1]), 64'h08);
      check_vec("ram_r2_l2", 64'(ram[2][2]), 64'h09);
      check_vec("ram_r3_l2", 64'(ram[3][2]), 64'h0C);
      check_vec("ram_r0_l0", 64'(ram[0][0]), 64'h01);

      run_load(8'h21, 1'b0, 1'b1, -1, -1);
      check_vec("ram_gap_r1_l1", 64'(ram[1][1]), 64'h25);

      run_load(8'h41, 1'b0, 1'b0, 5, -1);

      run_load(8'h61, 1'b0, 1'b0, -1, 7);
      run_load(8'h81, 1'b0, 1'b0, -1, -1);
      check_vec("ram_new_r3_l0", 64'(ram[3][0]), 64'h8A);

      run_load(8'hFF, 1'b1, 1'b0, -1, -1);
`ifdef RAM_ROW_LOADER_CHECKSUM_EN
      check_vec("cks_bf4_hold", 64'(bus.checksum), 64'h0000_0BF4);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_vec("cks_zero_after_start", 64'(bus.checksum), 64'd0);
      rst = 1'b1;
      #1;
      check_vec("cks_rst", 64'(bus.checksum), 64'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
